ammod_pulse_ctrl: RTL

AMMOD_PULSE_CTRL -- requirements
Module: ammod_pulse_ctrl

---
 rtl/ammod_pulse_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ammod_pulse_ctrl.sv
// ammod_pulse_ctrl
//   Schedules AM-modulator pulses from a 2-deep command FIFO against a
//   free-running 32-bit time base. Each command holds a start time, an
//   envelope address/length and the modulator parameters. Envelope
//   addresses are issued one per clock while playing. A LAT-deep copy of
//   env_en marks valid modulator output words.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_tstart                  absolute start time (clocks)
//   cmd_envaddr, cmd_envlen     first envelope word address, length in words
//   cmd_freqaddr, cmd_pini      frequency-table address, initial phase
//   cmd_ampx, cmd_ampy          complex amplitude
//   tcnt                        phase time to the modulator (tnow one clock late)
//   envaddr, freqaddr           memory read addresses
//   pini, ampx, ampy            parameters of the active pulse
//   env_en                      envelope address valid this clock
//   out_gate                    env_en delayed by LAT clocks
//   pulse_done                  one-clock strobe on the falling edge of out_gate
//   late                        sticky: a pulse started after its tstart
//   tnow                        free-running time counter
module ammod_pulse_ctrl #(
  parameter int unsigned NSLICE = 16,
  parameter int unsigned ENVAW  = 12,
  parameter int unsigned LAT    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_tstart,
  input  logic [ENVAW-1:0] cmd_envaddr,
  input  logic [ENVAW-1:0] cmd_envlen,
  input  logic [7:0]       cmd_freqaddr,
  input  logic [16:0]      cmd_pini,
  input  logic [15:0]      cmd_ampx,
  input  logic [15:0]      cmd_ampy,
  output logic [17:0]      tcnt,
  output logic [ENVAW-1:0] envaddr,
  output logic [7:0]       freqaddr,
  output logic [16:0]      pini,
  output logic [15:0]      ampx,
  output logic [15:0]      ampy,
  output logic             env_en,
  output logic             out_gate,
  output logic             pulse_done,
  output logic             late,
  output logic [31:0]      tnow
);

  // NSLICE only describes the downstream modulator; reject nonsense values.
  if (NSLICE < 1 || LAT < 1 || ENVAW < 1) begin : g_bad_param
    $error("ammod_pulse_ctrl: NSLICE, LAT and ENVAW must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLAY} state_t;

  typedef struct packed {
    logic [31:0]      tstart;
    logic [ENVAW-1:0] envaddr;
    logic [ENVAW-1:0] envlen;
    logic [7:0]       freqaddr;
    logic [16:0]      pini;
    logic [15:0]      ampx;
    logic [15:0]      ampy;
  } cmd_t;

  // ---------------------------------------------------------------- time base
  logic [31:0] tnext;
  assign tnext = tnow + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      tnow <= '0;
      tcnt <= '0;
    end else begin
      tnow <= tnext;
      tcnt <= tnow[17:0];
    end
  end

  // ---------------------------------------------------------- command FIFO
  cmd_t       fifo_mem [2];
  cmd_t       in_cmd;
  cmd_t       head;
  logic       rptr, wptr;
  logic [1:0] count;
  logic       full, empty, push, pop;

  assign in_cmd    = {cmd_tstart, cmd_envaddr, cmd_envlen, cmd_freqaddr,
                      cmd_pini, cmd_ampx, cmd_ampy};
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign head      = fifo_mem[rptr];
  assign cmd_ready = ~full & ~reset;
  assign push      = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= in_cmd;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------------- FSM
  state_t           state, nxt;
  logic             latch, late_set;
  logic [31:0]      cur_tstart;
  logic [ENVAW-1:0] remain;
  logic [31:0]      diff;

  // Decisions look one clock ahead (tnow+1) so that env_en, a pure decode
  // of the state register, is high exactly in the clock where tnow == tstart.
  assign diff = tnext - cur_tstart;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    pop      = 1'b0;
    latch    = 1'b0;
    late_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // zero-length commands are dropped without touching any output
          if (head.envlen != '0) begin
            latch = 1'b1;
            nxt   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (diff == '0) begin
          nxt = S_PLAY;
        end else if (!diff[31]) begin
          late_set = 1'b1;
          nxt      = S_PLAY;
        end
      end
      S_PLAY: begin
        if (remain == ENVAW'(1)) begin
          nxt = S_IDLE;
          if (!empty) begin
            pop = 1'b1;
            if (head.envlen != '0) begin
              latch = 1'b1;
              nxt   = (head.tstart == tnext) ? S_PLAY : S_WAIT;
            end
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign env_en = (state == S_PLAY);

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_tstart <= '0;
      envaddr    <= '0;
      remain     <= '0;
      freqaddr   <= '0;
      pini       <= '0;
      ampx       <= '0;
      ampy       <= '0;
      late       <= 1'b0;
    end else begin
      if (latch) begin
        cur_tstart <= head.tstart;
        envaddr    <= head.envaddr;
        remain     <= head.envlen;
        freqaddr   <= head.freqaddr;
        pini       <= head.pini;
        ampx       <= head.ampx;
        ampy       <= head.ampy;
      end else if (state == S_PLAY) begin
        envaddr <= envaddr + ENVAW'(1);
        remain  <= remain - ENVAW'(1);
      end
      if (late_set) late <= 1'b1;
    end
  end

  // ------------------------------------------------------ output gating
  logic [LAT-1:0] gate_sr, gate_next;
  logic           gate_q;

  if (LAT == 1) begin : g_lat1
    assign gate_next = env_en;
  end else begin : g_latn
    assign gate_next = {gate_sr[LAT-2:0], env_en};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_sr <= '0;
      gate_q  <= 1'b0;
    end else begin
      gate_sr <= gate_next;
      gate_q  <= out_gate;
    end
  end

  assign out_gate   = gate_sr[LAT-1];
  // back-to-back pulses merge into one gate, hence one strobe at its end
  assign pulse_done = gate_q & ~out_gate;

endmodule
